// File: rtl/riscv_irq_arbiter.sv
// Interrupt source arbiter: captures rising edges on 18 interrupt lines into a
// pending vector, selects the highest-priority enabled pending line and presents
// it to the core as a level request until it is acknowledged or withdrawn.
module riscv_irq_arbiter #(
    parameter bit PULP_SECURE = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        irq_software_i,
    input  logic        irq_timer_i,
    input  logic        irq_external_i,
    input  logic [14:0] irq_fast_i,
    input  logic [17:0] irq_enable_i,
    input  logic [17:0] irq_sec_attr_i,
    output logic        irq_o,
    output logic [4:0]  irq_id_o,
    output logic        irq_sec_o,
    input  logic        irq_ack_i,
    input  logic [4:0]  irq_ack_id_i,
    output logic [17:0] pending_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        ACKED   = 2'd2
    } state_t;

    // Bit order everywhere: {fast[14:0], external, timer, software}
    logic [17:0] lines;
    logic [17:0] prev_q;
    logic [17:0] pending_q;
    logic [17:0] pending_d;
    logic [17:0] set_vec;
    logic [17:0] ack_mask;
    logic [17:0] candidate;

    logic        win_valid;
    logic [4:0]  win_idx;

    state_t      state_q;
    logic        irq_q;
    logic [4:0]  id_q;
    logic        sec_q;
    logic [4:0]  sel_q;

    assign lines     = {irq_fast_i, irq_external_i, irq_timer_i, irq_software_i};
    assign candidate = pending_q & irq_enable_i;

    // Map a pending-vector bit index to its interrupt id.
    function automatic logic [4:0] idx_to_id(input logic [4:0] idx);
        logic [4:0] id;
        case (idx)
            5'd0:    id = 5'd3;
            5'd1:    id = 5'd7;
            5'd2:    id = 5'd11;
            default: id = idx + 5'd13;
        endcase
        return id;
    endfunction

    // Rising-edge detection per line.
    for (genvar gi = 0; gi < 18; gi++) begin : g_edge
        assign set_vec[gi] = lines[gi] & ~prev_q[gi];
    end

    // Decode the acknowledged id into a clear mask; unmapped ids clear nothing.
    always_comb begin
        ack_mask = '0;
        if (irq_ack_i) begin
            case (irq_ack_id_i)
                5'd3:    ack_mask[0] = 1'b1;
                5'd7:    ack_mask[1] = 1'b1;
                5'd11:   ack_mask[2] = 1'b1;
                default: begin
                    for (int k = 0; k < 15; k++) begin
                        if (irq_ack_id_i == 5'(16 + k)) begin
                            ack_mask[3 + k] = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // A set in the same cycle as a clear wins, so the clear is applied first.
    assign pending_d = (pending_q & ~ack_mask) | set_vec;

    // Priority select: later assignments override earlier ones, so scan from
    // lowest priority (timer, software, external, fast[0]..fast[14]) upward.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 5'd0;
        if (candidate[1]) begin
            win_valid = 1'b1;
            win_idx   = 5'd1;
        end
        if (candidate[0]) begin
            win_valid = 1'b1;
            win_idx   = 5'd0;
        end
        if (candidate[2]) begin
            win_valid = 1'b1;
            win_idx   = 5'd2;
        end
        for (int k = 3; k < 18; k++) begin
            if (candidate[k]) begin
                win_valid = 1'b1;
                win_idx   = 5'(k);
            end
        end
    end

    // Line history and pending vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            prev_q    <= lines;
            pending_q <= pending_d;
        end
    end

    // Request FSM with registered request, id and secure outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
            id_q    <= 5'd0;
            sec_q   <= 1'b0;
            sel_q   <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        state_q <= PRESENT;
                        irq_q   <= 1'b1;
                        id_q    <= idx_to_id(win_idx);
                        sec_q   <= PULP_SECURE ? irq_sec_attr_i[win_idx] : 1'b0;
                        sel_q   <= win_idx;
                    end
                end
                PRESENT: begin
                    if (irq_ack_i) begin
                        state_q <= ACKED;
                        irq_q   <= 1'b0;
                        sec_q   <= 1'b0;
                    end else if (!(irq_enable_i[sel_q] && pending_q[sel_q])) begin
                        // Withdraw without touching the pending bit.
                        state_q <= IDLE;
                        irq_q   <= 1'b0;
                        sec_q   <= 1'b0;
                    end
                end
                ACKED: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                    sec_q   <= 1'b0;
                end
            endcase
        end
    end

    assign irq_o     = irq_q;
    assign irq_id_o  = id_q;
    assign irq_sec_o = sec_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// Randomized and directed stimulus for riscv_irq_arbiter, checked cycle by
// cycle against a behavioural model through a scoreboard queue.
module tb_riscv_irq_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sw, tm, ex;
    logic [14:0] fast;
    logic [17:0] en, attr;
    logic        ack;
    logic [4:0]  ack_id;
    logic        irq_o, irq_sec_o;
    logic [4:0]  irq_id_o;
    logic [17:0] pending_o;

    always #5 clk = ~clk;

    riscv_irq_arbiter #(.PULP_SECURE(1'b1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq_software_i (sw),
        .irq_timer_i    (tm),
        .irq_external_i (ex),
        .irq_fast_i     (fast),
        .irq_enable_i   (en),
        .irq_sec_attr_i (attr),
        .irq_o          (irq_o),
        .irq_id_o       (irq_id_o),
        .irq_sec_o      (irq_sec_o),
        .irq_ack_i      (ack),
        .irq_ack_id_i   (ack_id),
        .pending_o      (pending_o)
    );

    typedef struct {
        bit        irq;
        int        id;
        bit        sec;
        bit [17:0] pend;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   prio[18];

    // Behavioural model state
    bit [17:0] m_prev, m_pend;
    int        m_phase;   // 0 idle, 1 presenting, 2 one-cycle gap after ack
    int        m_bit, m_id;
    bit        m_sec, m_irq;

    function automatic int bit_id(int b);
        if (b == 0) return 3;
        if (b == 1) return 7;
        if (b == 2) return 11;
        return 16 + (b - 3);
    endfunction

    function automatic int id_bit(int id);
        if (id == 3) return 0;
        if (id == 7) return 1;
        if (id == 11) return 2;
        if (id >= 16 && id <= 30) return id - 13;
        return -1;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev  = '0;
        m_pend  = '0;
        m_phase = 0;
        m_irq   = 1'b0;
        m_sec   = 1'b0;
        m_id    = 0;
        m_bit   = 0;
    endtask

    // Advance the model by one clock using the inputs now on the DUT pins.
    task automatic model_step();
        bit [17:0] lv;
        int        w, ab;
        exp_t      e;
        lv = {fast, ex, tm, sw};
        case (m_phase)
            0: begin
                w = -1;
                for (int i = 0; i < 18; i++)
                    if (w < 0 && m_pend[prio[i]] && en[prio[i]]) w = prio[i];
                if (w >= 0) begin
                    m_phase = 1;
                    m_bit   = w;
                    m_id    = bit_id(w);
                    m_sec   = attr[w];
                    m_irq   = 1'b1;
                end
            end
            1: begin
                if (ack) begin
                    m_phase = 2;
                    m_irq   = 1'b0;
                    m_sec   = 1'b0;
                end else if (!en[m_bit] || !m_pend[m_bit]) begin
                    m_phase = 0;
                    m_irq   = 1'b0;
                    m_sec   = 1'b0;
                end
            end
            default: m_phase = 0;
        endcase
        if (ack) begin
            ab = id_bit(int'(ack_id));
            if (ab >= 0) m_pend[ab] = 1'b0;
        end
        m_pend = m_pend | (lv & ~m_prev);
        m_prev = lv;
        e.irq  = m_irq;
        e.id   = m_id;
        e.sec  = m_sec;
        e.pend = m_pend;
        q.push_back(e);
    endtask

    // One clock: predict, let the edge happen, drop the ack pulse.
    task automatic tick();
        model_step();
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic wait_present(int bound);
        int i;
        for (i = 0; i < bound && !m_irq; i++) tick();
        if (!m_irq) begin
            errors++;
            checks++;
            $display("FAIL wait_present actual=timeout required=request within %0d cycles", bound);
        end
    endtask

    task automatic ack_current();
        ack    = 1'b1;
        ack_id = m_id[4:0];
        $display("ack id=%0d time=%0t", m_id, $time);
        tick();
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("reset_irq", int'(irq_o), 0);
        chk("reset_id", int'(irq_id_o), 0);
        chk("reset_sec", int'(irq_sec_o), 0);
        chk("reset_pending", int'(pending_o), 0);
        model_reset();
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare DUT outputs after each edge against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("irq_o", int'(irq_o), int'(e.irq));
                chk("pending_o", int'(pending_o), int'(e.pend));
                if (e.irq) begin
                    chk("irq_id_o", int'(irq_id_o), e.id);
                    chk("irq_sec_o", int'(irq_sec_o), int'(e.sec));
                end
            end
        end
    end

    // Stimulus
    initial begin
        for (int i = 0; i < 15; i++) prio[i] = 17 - i;
        prio[15] = 2;
        prio[16] = 0;
        prio[17] = 1;
        model_reset();
        rst_n = 1'b0;
        sw = 0; tm = 0; ex = 0; fast = '0;
        en = '1; attr = '0; ack = 0; ack_id = '0;
        #3;
        chk("reset_irq", int'(irq_o), 0);
        chk("reset_id", int'(irq_id_o), 0);
        chk("reset_sec", int'(irq_sec_o), 0);
        chk("reset_pending", int'(pending_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single timer pulse
        tm = 1; tick(); tm = 0;
        run(2);
        chk("timer_present", int'(m_irq), 1);
        ack_current();
        run(4);

        // Simultaneous software, external, fast[2]: expect 18, 11, 3
        sw = 1; ex = 1; fast[2] = 1; tick();
        sw = 0; ex = 0; fast[2] = 0;
        repeat (3) begin
            wait_present(10);
            ack_current();
        end
        run(4);

        // No preemption by a higher line while presenting
        fast[0] = 1; tick(); fast[0] = 0;
        wait_present(10);
        fast[9] = 1; tick(); fast[9] = 0;
        run(3);
        ack_current();
        wait_present(10);
        ack_current();
        run(3);

        // Withdraw by disabling external, then re-enable
        ex = 1; tick(); ex = 0;
        wait_present(10);
        en[2] = 0; run(3);
        en[2] = 1;
        wait_present(10);
        ack_current();
        run(3);

        // Ack of timer coinciding with a new timer edge
        tm = 1; tick(); tm = 0;
        wait_present(10);
        tm = 1; ack_current(); tm = 0;
        wait_present(10);
        ack_current();
        run(3);

        // Secure attribute on fast[5], then reset while presenting
        attr[8] = 1; fast[5] = 1; tick(); fast[5] = 0;
        wait_present(10);
        run(1);
        mid_reset();
        run(3);

        // Randomized traffic
        attr = 18'($urandom);
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                int b;
                b = $urandom_range(0, 17);
                if (b == 0) sw = ~sw;
                else if (b == 1) tm = ~tm;
                else if (b == 2) ex = ~ex;
                else fast[b - 3] = ~fast[b - 3];
            end
            if ($urandom_range(0, 15) == 0) en[$urandom_range(0, 17)] = 1'b0;
            if ($urandom_range(0, 7) == 0) en = '1;
            if (m_irq && $urandom_range(0, 2) == 0) begin
                ack    = 1'b1;
                ack_id = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : m_id[4:0];
                $display("ack id=%0d presented=%0d time=%0t", ack_id, m_id, $time);
            end else if ($urandom_range(0, 19) == 0) begin
                ack    = 1'b1;
                ack_id = 5'($urandom_range(0, 31));
            end
            if (c == 1000) mid_reset();
            tick();
        end

        en = '1; sw = 0; tm = 0; ex = 0; fast = '0;
        run(4);
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
